// File: rtl/obi_mux_n_to_1.sv
// N-to-1 OBI multiplexer: arbitrates NUM_MASTERS masters onto one slave port and
// routes in-order read responses back to their issuers through an index FIFO.
module obi_mux_n_to_1 #(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_RR          = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_MASTERS-1:0]          m_req_i,
  output logic [NUM_MASTERS-1:0]          m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]          m_rvalid_o,
  output logic [NUM_MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic                            s_req_o,
  input  logic                            s_gnt_i,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic                            s_we_o,
  output logic [DATA_W/8-1:0]             s_be_o,
  output logic [DATA_W-1:0]               s_wdata_o,
  input  logic                            s_rvalid_i,
  input  logic [DATA_W-1:0]               s_rdata_i,
  output logic                            err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NUM_MASTERS - 1)) ? '0 : i + idx_t'(1);
  endfunction

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  idx_t              rr_ptr;
  logic              locked;
  idx_t              lock_idx;
  logic [ADDR_W-1:0] lock_addr;
  logic              lock_we;
  logic [BE_W-1:0]   lock_be;
  logic [DATA_W-1:0] lock_wdata;

  idx_t              fifo [MAX_OUTSTANDING];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              err_q;

  idx_t              arb_idx;
  idx_t              arb_cand;
  logic              arb_found;
  idx_t              sel;
  idx_t              head;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              can_issue;
  logic              handshake;
  logic              lock_bad;

  // Walk the request vector starting at the RR pointer (or index 0 for fixed priority).
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    arb_cand  = (ARB_RR != 0) ? rr_ptr : '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!arb_found && m_req_i[arb_cand]) begin
        arb_idx   = arb_cand;
        arb_found = 1'b1;
      end
      arb_cand = next_idx(arb_cand);
    end
  end

  assign sel = locked ? lock_idx : arb_idx;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel == idx_t'(i)) begin
        sel_addr  = m_addr_i[i*ADDR_W +: ADDR_W];
        sel_we    = m_we_i[i];
        sel_be    = m_be_i[i*BE_W +: BE_W];
        sel_wdata = m_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign s_req_o   = |m_req_i;
  assign s_addr_o  = s_req_o ? sel_addr  : '0;
  assign s_we_o    = s_req_o & sel_we;
  assign s_be_o    = s_req_o ? sel_be    : '0;
  assign s_wdata_o = s_req_o ? sel_wdata : '0;

  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty     = (count == '0);
  assign pop       = s_rvalid_i & ~empty;
  // A response retiring this cycle frees the slot the new read would need.
  assign can_issue = ~full | pop;
  assign handshake = s_req_o & s_gnt_i & can_issue;
  assign push      = handshake & ~sel_we;
  assign head      = fifo[rd_ptr];

  assign lock_bad = locked & ((sel_addr != lock_addr) | (sel_we != lock_we) |
                              (sel_be != lock_be) | (sel_wdata != lock_wdata));

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (handshake && sel == idx_t'(i)) m_gnt_o[i] = 1'b1;
      if (pop && head == idx_t'(i)) begin
        m_rvalid_o[i]                 = 1'b1;
        m_rdata_o[i*DATA_W +: DATA_W] = s_rdata_i;
      end
    end
  end

  // Hold the stalled winner and its address phase until the slave accepts it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      locked     <= 1'b0;
      lock_idx   <= '0;
      lock_addr  <= '0;
      lock_we    <= 1'b0;
      lock_be    <= '0;
      lock_wdata <= '0;
    end else if (handshake) begin
      rr_ptr <= next_idx(sel);
      locked <= 1'b0;
    end else if (s_req_o && !s_gnt_i && !locked) begin
      locked     <= 1'b1;
      lock_idx   <= sel;
      lock_addr  <= sel_addr;
      lock_we    <= sel_we;
      lock_be    <= sel_be;
      lock_wdata <= sel_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= sel;
        wr_ptr       <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop) count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Stray responses and address-phase changes under lock both stick until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((s_rvalid_i && empty) || lock_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule
